uart_rx: RTL and testbench

UART receiver: recovers 8N1 frames (start bit, 8 data bits LSB-first, one stop bit, line idle high) from an asynchronous serial line and presents each byte on a parallel port with a one-cycle completion pulse. Sits between the board RX pin and the byte-level consumer (FIFO or command parser). Timing comes from the shared baud generator, which supplies a tick at OVERSAMPLE× the baud rate.

---
 rtl/uart_rx.sv | 140 ++++++++++++++
 tb/tb_uart_rx.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, OVERSAMPLE ticks per bit, 3-sample
// majority vote at mid-bit, one-cycle completion / framing-error pulses.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx_serial_data,
    output logic [7:0] rx_data,
    output logic       rx_finish,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] S_FIRST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] S_MID   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] S_DEC   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] S_LAST  = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic [1:0]    sync_r;
    state_t        state_r;
    logic [CW-1:0] s_cnt_r;
    logic [2:0]    b_cnt_r;
    logic [7:0]    shift_r;
    logic [1:0]    samp_r;
    logic          rxs_s;
    logic          vote_s;
    logic [CW-1:0] s_next_s;

    assign rxs_s    = sync_r[1];
    assign vote_s   = majority3(samp_r[1], samp_r[0], rxs_s);
    assign s_next_s = (s_cnt_r == S_LAST) ? {CW{1'b0}} : s_cnt_r + CW'(1);

    // Two-flop synchronizer for the asynchronous line; idles high out of reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], rx_serial_data};
        end
    end

    // Frame state machine; pulses clear every cycle, everything else moves on ticks only.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_r      <= IDLE;
            s_cnt_r      <= {CW{1'b0}};
            b_cnt_r      <= 3'd0;
            shift_r      <= 8'h00;
            samp_r       <= 2'b00;
            rx_data      <= 8'h00;
            rx_finish    <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            rx_finish    <= 1'b0;
            rx_frame_err <= 1'b0;
            if (rx_en) begin
                if ((s_cnt_r == S_FIRST) || (s_cnt_r == S_MID)) begin
                    samp_r <= {samp_r[0], rxs_s};
                end
                case (state_r)
                    IDLE: begin
                        if (!rxs_s) begin
                            state_r <= START;
                            s_cnt_r <= CW'(1);
                            rx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        s_cnt_r <= s_next_s;
                        if ((s_cnt_r == S_DEC) && vote_s) begin
                            state_r <= IDLE;
                            s_cnt_r <= {CW{1'b0}};
                            rx_busy <= 1'b0;
                        end else if (s_cnt_r == S_LAST) begin
                            state_r <= DATA;
                            b_cnt_r <= 3'd0;
                        end
                    end
                    DATA: begin
                        s_cnt_r <= s_next_s;
                        if (s_cnt_r == S_DEC) begin
                            shift_r <= {vote_s, shift_r[7:1]};
                        end
                        if (s_cnt_r == S_LAST) begin
                            if (b_cnt_r == 3'd7) begin
                                state_r <= STOP;
                            end else begin
                                b_cnt_r <= b_cnt_r + 3'd1;
                            end
                        end
                    end
                    STOP: begin
                        s_cnt_r <= s_next_s;
                        // Leave at mid-stop-bit so an early next start edge is still caught.
                        if (s_cnt_r == S_DEC) begin
                            s_cnt_r <= {CW{1'b0}};
                            if (vote_s) begin
                                rx_data   <= shift_r;
                                rx_finish <= 1'b1;
                                state_r   <= IDLE;
                                rx_busy   <= 1'b0;
                            end else begin
                                rx_frame_err <= 1'b1;
                                state_r      <= BRK;
                            end
                        end
                    end
                    BRK: begin
                        if (rxs_s) begin
                            state_r <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        s_cnt_r <= {CW{1'b0}};
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: rx_en ticks every 4 clocks, so a nominal bit is 64 clocks.
module tb_uart_rx;

    logic       clk_in = 1'b0;
    logic       rst;
    logic       rx_en;
    logic       rx_serial_data;
    logic [7:0] rx_data;
    logic       rx_finish;
    logic       rx_frame_err;
    logic       rx_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int div      = 0;

    int fin_cnt = 0, err_cnt = 0, both_cnt = 0, rise_cnt = 0;
    int tick_ctr = 0, fin_tick = -1, err_tick = -1, fall_tick = -1;
    logic busy_prev = 1'b0;
    logic [7:0] got_q[$];

    int fin_base, err_base, rise_base, q_base;
    logic [7:0] b2b_v [3] = '{8'h00, 8'hFF, 8'h7E};

    always #5 clk_in = ~clk_in;

    uart_rx #(.OVERSAMPLE(16)) dut (
        .clk_in         (clk_in),
        .rst            (rst),
        .rx_en          (rx_en),
        .rx_serial_data (rx_serial_data),
        .rx_data        (rx_data),
        .rx_finish      (rx_finish),
        .rx_frame_err   (rx_frame_err),
        .rx_busy        (rx_busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        div   = (div == 3) ? 0 : div + 1;
        rx_en = (div == 0);
    endtask

    task automatic hold(input logic v, input int n);
        rx_serial_data = v;
        repeat (n) step();
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop_v,
                              input int glitch_bit, input bit align);
        if (align) begin
            while (div != 3) step();
        end
        hold(1'b0, bit_clks);
        for (int k = 0; k < 8; k++) begin
            if (k == glitch_bit) begin
                hold(1'b1, 32);
                hold(1'b0, 4);
                hold(1'b1, bit_clks - 36);
            end else begin
                hold(b[k], bit_clks);
            end
        end
        hold(stop_v, bit_clks);
    endtask

    // Pulse and timing observer, sampled just after each rising edge.
    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            if (rx_busy && !busy_prev) begin
                tick_ctr = 0;
                rise_cnt++;
            end else if (rx_en) begin
                tick_ctr++;
            end
            if (busy_prev && !rx_busy) fall_tick = tick_ctr;
            if (rx_finish) begin
                fin_cnt++;
                fin_tick = tick_ctr;
                got_q.push_back(rx_data);
            end
            if (rx_frame_err) begin
                err_cnt++;
                err_tick = tick_ctr;
            end
            if (rx_finish && rx_frame_err) both_cnt++;
            busy_prev = rx_busy;
        end
    end

    initial begin
        rst = 1'b1;
        rx_en = 1'b0;
        rx_serial_data = 1'b1;
        repeat (4) step();
        check_eq("rst_data", {24'd0, rx_data}, 32'h00);
        check_eq("rst_finish", {31'd0, rx_finish}, 32'd0);
        check_eq("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        check_eq("rst_busy", {31'd0, rx_busy}, 32'd0);
        rst = 1'b0;
        hold(1'b1, 64);

        // Two nominal frames
        fin_base = fin_cnt; err_base = err_cnt;
        send_frame(8'h55, 64, 1'b1, -1, 1'b1);
        hold(1'b1, 32);
        check_eq("f55_cnt", fin_cnt - fin_base, 1);
        check_eq("f55_data", {24'd0, rx_data}, 32'h55);
        check_eq("f55_tick", fin_tick, 153);
        check_eq("f55_busy_fall", fall_tick, 153);
        send_frame(8'hA3, 64, 1'b1, -1, 1'b1);
        hold(1'b1, 32);
        check_eq("fa3_cnt", fin_cnt - fin_base, 2);
        check_eq("fa3_data", {24'd0, rx_data}, 32'hA3);
        check_eq("nom_ferr", err_cnt - err_base, 0);

        // False start: 4 ticks low
        fin_base = fin_cnt; err_base = err_cnt; rise_base = rise_cnt;
        while (div != 3) step();
        hold(1'b0, 16);
        hold(1'b1, 128);
        check_eq("fs_rise", rise_cnt - rise_base, 1);
        check_eq("fs_fall_tick", fall_tick, 9);
        check_eq("fs_fin", fin_cnt - fin_base, 0);
        check_eq("fs_ferr", err_cnt - err_base, 0);
        check_eq("fs_busy", {31'd0, rx_busy}, 32'd0);

        // Single-tick glitch at sample 8 of bit 2
        fin_base = fin_cnt; err_base = err_cnt;
        send_frame(8'h3C, 64, 1'b1, 2, 1'b1);
        hold(1'b1, 64);
        check_eq("gl_cnt", fin_cnt - fin_base, 1);
        check_eq("gl_data", {24'd0, rx_data}, 32'h3C);
        check_eq("gl_ferr", err_cnt - err_base, 0);

        // Bad stop bit, long break, then a good frame
        fin_base = fin_cnt; err_base = err_cnt;
        send_frame(8'hFF, 64, 1'b0, -1, 1'b1);
        hold(1'b0, 30 * 64);
        check_eq("brk_ferr", err_cnt - err_base, 1);
        check_eq("brk_tick", err_tick, 153);
        check_eq("brk_fin", fin_cnt - fin_base, 0);
        check_eq("brk_data_kept", {24'd0, rx_data}, 32'h3C);
        check_eq("brk_busy", {31'd0, rx_busy}, 32'd1);
        hold(1'b1, 128);
        check_eq("brk_exit_busy", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h81, 64, 1'b1, -1, 1'b1);
        hold(1'b1, 64);
        check_eq("brk_ferr_once", err_cnt - err_base, 1);
        check_eq("f81_cnt", fin_cnt - fin_base, 1);
        check_eq("f81_data", {24'd0, rx_data}, 32'h81);

        // Back-to-back frames, line 3% fast then 3% slow
        for (int r = 0; r < 2; r++) begin
            fin_base = fin_cnt; err_base = err_cnt; q_base = got_q.size();
            for (int i = 0; i < 3; i++) begin
                send_frame(b2b_v[i], (r == 0) ? 62 : 66, 1'b1, -1, (i == 0));
            end
            hold(1'b1, 128);
            check_eq("b2b_cnt", fin_cnt - fin_base, 3);
            check_eq("b2b_ferr", err_cnt - err_base, 0);
            for (int i = 0; i < 3; i++) begin
                check_eq("b2b_data",
                         (got_q.size() > q_base + i) ? {24'd0, got_q[q_base + i]} : 32'hDEAD,
                         {24'd0, b2b_v[i]});
            end
        end

        // Reset during data bit 4
        fin_base = fin_cnt; err_base = err_cnt;
        while (div != 3) step();
        hold(1'b0, 64 + 4 * 64 + 32);
        check_eq("ab_busy_pre", {31'd0, rx_busy}, 32'd1);
        rst = 1'b1;
        rx_serial_data = 1'b1;
        repeat (3) step();
        check_eq("ab_rst_data", {24'd0, rx_data}, 32'h00);
        check_eq("ab_rst_busy", {31'd0, rx_busy}, 32'd0);
        check_eq("ab_rst_fin", {31'd0, rx_finish}, 32'd0);
        rst = 1'b0;
        hold(1'b1, 128);
        check_eq("ab_no_pulse", (fin_cnt - fin_base) + (err_cnt - err_base), 0);
        send_frame(8'h12, 64, 1'b1, -1, 1'b1);
        hold(1'b1, 64);
        check_eq("f12_cnt", fin_cnt - fin_base, 1);
        check_eq("f12_data", {24'd0, rx_data}, 32'h12);
        check_eq("f12_ferr", err_cnt - err_base, 0);

        check_eq("fin_ferr_overlap", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
